ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0: RTL and testbench
================================================================

Name: ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0

Overview:
- Downstream of the APM stage that computes a0_hi plus the signed carry from the low-part subtraction, inside the inverse-sqrt Newton iteration.
- Re-aligns the low-part bits and the valid flag to the APM's configurable latency.
- Merges the 10-bit high sum with the low bits, then applies underflow saturation and a 1-bit normalisation shift.
- Drives a registered, valid-qualified result to the next iteration stage, plus a sticky underflow flag for the status path.

Parameters:
- LO_WIDTH, 16, width of the low-part result bits carried alongside the APM.
- LATENCY_CONFIG, 1, latency configuration of the enclosing core.
- PIPE_STAGE_NUM_MAX, 1, maximum pipeline stage count of the enclosing core.
- MAN_WIDTH, 52, mantissa width of the core (informational; checked to be >= 9+LO_WIDTH-1 by assertion).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  qualifies i_lo; asserted in the same cycle the APM inputs are presented.
- i_lo  input  LO_WIDTH  low bits of a0_lo - a1*y, below the 2-bit carry field.
- i_hi_sum  input  10  APM output a0_hi + sign-extended carry; valid APM_LAT cycles after i_valid.
- i_clr_flag  input  1  clears the sticky underflow flag.
- o_valid  output  1  result valid.
- o_res  output  9+LO_WIDTH  merged, normalised result.
- o_exp_dec  output  1  result was shifted left one bit; the exponent must be decremented.
- o_underflow  output  1  this result saturated to zero.
- o_underflow_sticky  output  1  at least one underflow has occurred since the last reset or clear.

Behaviour:
- Interface (already decided): one clock, i_clk; reset i_rst is synchronous and active-high.
- APM_LAT = 1 if LATENCY_CONFIG >= PIPE_STAGE_NUM_MAX - 10, else 0. This matches the APM X/Z input register setting.
- Alignment delay line:
  - depth APM_LAT on {i_valid, i_lo};
  - with APM_LAT=0 it is a wire.
- Output register stage. Total latency from i_valid to o_valid = APM_LAT + 1 cycles.
- Each aligned-valid cycle, with h = i_hi_sum and l = delayed i_lo:
  - h[9]=1 (negative, borrow beyond the high part): o_res=0, o_underflow=1, o_exp_dec=0.
  - h[9]=0, h[8]=1: o_res={h[8:0], l}, o_exp_dec=0.
  - h[9]=0, h[8]=0: o_res={h[7:0], l, 1'b0}, o_exp_dec=1.
- i_hi_sum is sampled only in aligned-valid cycles. In other cycles:
  - o_valid=0;
  - o_res, o_exp_dec and o_underflow hold their previous values.
- Sticky flag, evaluated each cycle:
  - clear if i_clr_flag=1;
  - else set if an underflow result is being registered.
  - If both happen in the same cycle, the set wins, so a new event is never lost.
- Reset, including mid-stream:
  - delay line valid bits, o_valid, o_res, o_exp_dec, o_underflow and o_underflow_sticky all go to 0 on the next edge;
  - samples in flight are discarded;
  - no output valid appears until APM_LAT+1 cycles after the first post-reset i_valid.
- Back-to-back i_valid every cycle is supported. There is no backpressure: one result per accepted input, in order.

Decomposition:
- Shared package:
  - HI_SUM_W=10;
  - the APM_LAT derivation function (also used by the APM instantiation, so the two stay consistent);
  - the result-flag encoding.
- One sub-module: ipsxe_floating_point_delay_line_v1_0, a parameterised width/depth shift register with synchronous reset on the valid bit only, instantiated for the {valid, lo} alignment.

Test Plan:
- Normal, APM_LAT=1, LO_WIDTH=16: i_valid=1, i_lo=16'h1234; next cycle i_hi_sum=10'h1A5 -> two cycles after i_valid: o_valid=1, o_res=25'h1A51234, o_exp_dec=0, o_underflow=0.
- Normalise: i_hi_sum=10'h0A5, i_lo=16'h8001 -> o_res={8'hA5, 16'h8001, 1'b0}=25'h14B0002, o_exp_dec=1.
- Underflow and sticky:
  - i_hi_sum=10'h3FF -> o_res=0, o_underflow=1, o_underflow_sticky=1.
  - Three further normal samples keep sticky at 1.
  - i_clr_flag pulsed alone -> sticky goes to 0.
  - i_clr_flag in the same cycle as a new underflow -> sticky stays 1.
- Streaming: 8 consecutive i_valid cycles with distinct i_lo/i_hi_sum pairs -> 8 consecutive o_valid, same order, each o_res correct; the gap pattern 1,0,1 is reproduced exactly.
- Reset mid-operation: i_rst=1 one cycle while two samples are in flight -> neither emerges, all outputs 0, sticky 0; the first post-reset sample appears at the correct latency.
- Latency parameter: LATENCY_CONFIG=0, PIPE_STAGE_NUM_MAX=20 (APM_LAT=0), i_hi_sum presented with i_valid -> o_valid exactly one cycle later with correct merge.

Source files
------------

// File: rtl/ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0_pkg.sv
// Shared definitions for the inverse-sqrt hi/lo merge stage and the APM that feeds it.
package ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0_pkg;

  localparam int unsigned HI_SUM_W = 10;

  typedef enum logic [1:0] {
    ResNorm  = 2'd0,
    ResShift = 2'd1,
    ResUflow = 2'd2
  } res_kind_e;

  // Must match the APM X/Z input register setting, so both sides call this.
  function automatic int unsigned apm_lat(input int latency_config, input int pipe_stage_num_max);
    return (latency_config >= pipe_stage_num_max - 10) ? 32'd1 : 32'd0;
  endfunction

  function automatic res_kind_e classify(input logic [HI_SUM_W-1:0] hi_sum);
    if (hi_sum[9]) begin
      return ResUflow;
    end else if (hi_sum[8]) begin
      return ResNorm;
    end
    return ResShift;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_delay_line_v1_0.sv
// Width/depth shift register; only the valid bit is reset, depth 0 is a plain wire.
module ipsxe_floating_point_delay_line_v1_0 #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  if (Depth == 0) begin : g_wire
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_pipe
    logic [Depth-1:0] valid_q;
    logic [Width-1:0] data_q [Depth];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= valid_i;
        for (int i = 1; i < int'(Depth); i++) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      data_q[0] <= data_i;
      for (int i = 1; i < int'(Depth); i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    assign valid_o = valid_q[Depth-1];
    assign data_o  = data_q[Depth-1];
  end

endmodule

// File: rtl/ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0.sv
// Merges the APM high sum with the aligned low bits, saturates underflow and normalises by one bit.
module ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0
  import ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0_pkg::*;
#(
  parameter int LO_WIDTH           = 16,
  parameter int LATENCY_CONFIG     = 1,
  parameter int PIPE_STAGE_NUM_MAX = 1,
  parameter int MAN_WIDTH          = 52
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [LO_WIDTH-1:0]   i_lo,
  input  logic [HI_SUM_W-1:0]   i_hi_sum,
  input  logic                  i_clr_flag,
  output logic                  o_valid,
  output logic [9+LO_WIDTH-1:0] o_res,
  output logic                  o_exp_dec,
  output logic                  o_underflow,
  output logic                  o_underflow_sticky
);

  localparam int unsigned APM_LAT = apm_lat(LATENCY_CONFIG, PIPE_STAGE_NUM_MAX);
  localparam int          RES_W   = 9 + LO_WIDTH;

  logic                al_valid;
  logic [LO_WIDTH-1:0] al_lo;

  ipsxe_floating_point_delay_line_v1_0 #(
    .Width(LO_WIDTH),
    .Depth(APM_LAT)
  ) u_align (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .valid_i(i_valid),
    .data_i (i_lo),
    .valid_o(al_valid),
    .data_o (al_lo)
  );

  res_kind_e        kind;
  logic [RES_W-1:0] res_d;

  always_comb begin
    kind  = classify(i_hi_sum);
    res_d = '0;
    unique case (kind)
      ResNorm:  res_d = {i_hi_sum[8:0], al_lo};
      ResShift: res_d = {i_hi_sum[7:0], al_lo, 1'b0};
      default:  res_d = '0;
    endcase
  end

  logic             valid_q;
  logic [RES_W-1:0] res_q;
  logic             exp_dec_q;
  logic             underflow_q;
  logic             sticky_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= 1'b0;
      res_q       <= '0;
      exp_dec_q   <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      valid_q <= al_valid;
      if (al_valid) begin
        res_q       <= res_d;
        exp_dec_q   <= (kind == ResShift);
        underflow_q <= (kind == ResUflow);
      end
      // A new underflow beats a simultaneous clear so no event is lost.
      if (al_valid && (kind == ResUflow)) begin
        sticky_q <= 1'b1;
      end else if (i_clr_flag) begin
        sticky_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin : p_param_check
    assert (MAN_WIDTH >= 8 + LO_WIDTH)
    else $error("MAN_WIDTH too narrow for LO_WIDTH");
  end

  assign o_valid            = valid_q;
  assign o_res              = res_q;
  assign o_exp_dec          = exp_dec_q;
  assign o_underflow        = underflow_q;
  assign o_underflow_sticky = sticky_q;

endmodule

// File: tb/tb_ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0.sv
// Directed bench: APM_LAT=1 instance for most steps, APM_LAT=0 instance for the latency step.
module tb_ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] lo = '0;
  logic [9:0]  hi = '0;
  logic        clr = 1'b0;

  logic        v1, ed1, uf1, st1;
  logic [24:0] r1;
  logic        v0, ed0, uf0, st0;
  logic [24:0] r0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0 #(
    .LO_WIDTH(16), .LATENCY_CONFIG(1), .PIPE_STAGE_NUM_MAX(1), .MAN_WIDTH(52)
  ) dut_lat1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_lo(lo), .i_hi_sum(hi), .i_clr_flag(clr),
    .o_valid(v1), .o_res(r1), .o_exp_dec(ed1), .o_underflow(uf1), .o_underflow_sticky(st1)
  );

  ipsxe_floating_point_invsqrt_hi_lo_merge_v1_0 #(
    .LO_WIDTH(16), .LATENCY_CONFIG(0), .PIPE_STAGE_NUM_MAX(20), .MAN_WIDTH(52)
  ) dut_lat0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_lo(lo), .i_hi_sum(hi), .i_clr_flag(clr),
    .o_valid(v0), .o_res(r0), .o_exp_dec(ed0), .o_underflow(uf0), .o_underflow_sticky(st0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive inputs, then advance to just after the next rising edge.
  task automatic drive(input logic v, input logic [15:0] l, input logic [9:0] h, input logic c);
    valid = v;
    lo    = l;
    hi    = h;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] merge(input logic [9:0] h, input logic [15:0] l);
    if (h[9]) return 25'd0;
    if (h[8]) return {h[8:0], l};
    return {h[7:0], l, 1'b0};
  endfunction

  function automatic logic [9:0] hi_of(input int i);
    logic [9:0] k;
    k = 10'(i);
    return (i % 3 == 0) ? (10'h0C0 + k) : (10'h180 + k);
  endfunction

  initial begin
    logic [9:0]  pat;
    logic [24:0] held;

    // Reset state
    drive(0, 16'h0, 10'h0, 0);
    drive(0, 16'h0, 10'h0, 0);
    chk("rst_valid", 64'(v1), 64'd0);
    chk("rst_res", 64'(r1), 64'd0);
    chk("rst_exp_dec", 64'(ed1), 64'd0);
    chk("rst_underflow", 64'(uf1), 64'd0);
    chk("rst_sticky", 64'(st1), 64'd0);
    chk("rst_valid_lat0", 64'(v0), 64'd0);
    rst = 1'b0;

    // Normal merge, two-cycle latency
    drive(1, 16'h1234, 10'h000, 0);
    chk("norm_not_yet", 64'(v1), 64'd0);
    drive(0, 16'h0000, 10'h1A5, 0);
    chk("norm_valid", 64'(v1), 64'd1);
    chk("norm_res", 64'(r1), 64'h1A51234);
    chk("norm_exp_dec", 64'(ed1), 64'd0);
    chk("norm_underflow", 64'(uf1), 64'd0);

    // No aligned valid: outputs hold even with an underflow-looking hi_sum
    drive(0, 16'h0000, 10'h3FF, 0);
    chk("hold_valid", 64'(v1), 64'd0);
    chk("hold_res", 64'(r1), 64'h1A51234);
    chk("hold_sticky", 64'(st1), 64'd0);

    // Normalise shift
    drive(1, 16'h8001, 10'h000, 0);
    drive(0, 16'h0000, 10'h0A5, 0);
    chk("shift_valid", 64'(v1), 64'd1);
    chk("shift_res", 64'(r1), 64'h14B0002);
    chk("shift_exp_dec", 64'(ed1), 64'd1);

    // Underflow saturation
    drive(1, 16'hFFFF, 10'h000, 0);
    drive(0, 16'h0000, 10'h3FF, 0);
    chk("uf_res", 64'(r1), 64'd0);
    chk("uf_flag", 64'(uf1), 64'd1);
    chk("uf_exp_dec", 64'(ed1), 64'd0);
    chk("uf_sticky", 64'(st1), 64'd1);

    // Three normal samples keep sticky set
    drive(1, 16'h0001, 10'h000, 0);
    drive(1, 16'h0002, 10'h100, 0);
    chk("n1_res", 64'(r1), 64'h1000001);
    chk("n1_uf", 64'(uf1), 64'd0);
    chk("n1_sticky", 64'(st1), 64'd1);
    drive(1, 16'h0003, 10'h101, 0);
    chk("n2_res", 64'(r1), 64'h1010002);
    drive(0, 16'h0000, 10'h102, 0);
    chk("n3_res", 64'(r1), 64'h1020003);
    chk("n3_sticky", 64'(st1), 64'd1);
    drive(0, 16'h0000, 10'h000, 0);
    chk("n_idle_valid", 64'(v1), 64'd0);

    // Clear alone
    drive(0, 16'h0000, 10'h000, 1);
    chk("clr_sticky", 64'(st1), 64'd0);

    // Clear together with a new underflow: set wins
    drive(1, 16'h5555, 10'h000, 0);
    drive(0, 16'h0000, 10'h200, 1);
    chk("clr_set_valid", 64'(v1), 64'd1);
    chk("clr_set_uf", 64'(uf1), 64'd1);
    chk("clr_set_sticky", 64'(st1), 64'd1);
    drive(0, 16'h0000, 10'h000, 1);
    chk("clr2_sticky", 64'(st1), 64'd0);
    clr = 1'b0;

    // Streaming: eight back-to-back samples, then gap pattern 1,0,1
    pat  = 10'b10_1111_1111;
    held = r1;
    for (int i = 0; i <= 10; i++) begin
      drive((i < 10) ? pat[i] : 1'b0, 16'h1000 + 16'(i), (i > 0) ? hi_of(i - 1) : 10'h000, 0);
      if (i > 0) begin
        chk($sformatf("stream_valid_%0d", i - 1), 64'(v1), 64'(pat[i-1]));
        if (pat[i-1]) held = merge(hi_of(i - 1), 16'h1000 + 16'(i - 1));
        chk($sformatf("stream_res_%0d", i - 1), 64'(r1), 64'(held));
      end
    end

    // Reset mid-stream with samples in flight; sticky set beforehand
    drive(1, 16'h0000, 10'h000, 0);
    drive(0, 16'h0000, 10'h3FF, 0);
    chk("pre_rst_sticky", 64'(st1), 64'd1);
    drive(1, 16'hAAAA, 10'h000, 0);
    rst = 1'b1;
    drive(1, 16'hBBBB, 10'h1AA, 0);
    rst = 1'b0;
    chk("mid_rst_valid", 64'(v1), 64'd0);
    chk("mid_rst_res", 64'(r1), 64'd0);
    chk("mid_rst_sticky", 64'(st1), 64'd0);
    chk("mid_rst_uf", 64'(uf1), 64'd0);
    drive(0, 16'h0000, 10'h1BB, 0);
    chk("flush_valid", 64'(v1), 64'd0);
    chk("flush_res", 64'(r1), 64'd0);
    drive(1, 16'hCAFE, 10'h000, 0);
    chk("post_rst_not_yet", 64'(v1), 64'd0);
    drive(0, 16'h0000, 10'h155, 0);
    chk("post_rst_valid", 64'(v1), 64'd1);
    chk("post_rst_res", 64'(r1), 64'h155CAFE);
    chk("post_rst_exp_dec", 64'(ed1), 64'd0);

    // APM_LAT=0: hi_sum arrives with i_valid, result one cycle later
    chk("lat0_idle_valid", 64'(v0), 64'd0);
    drive(1, 16'h0F0F, 10'h0B3, 0);
    chk("lat0_valid", 64'(v0), 64'd1);
    chk("lat0_res", 64'(r0), 64'h1661E1E);
    chk("lat0_exp_dec", 64'(ed0), 64'd1);
    drive(0, 16'h0000, 10'h000, 0);
    chk("lat0_after_valid", 64'(v0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
